square_plotter: RTL

Buffered rectangle rasteriser between the snake game controller and `vga_adapter`. It accepts square-draw requests (top-left x, y, colour) through a valid/ready handshake into a small FIFO, then sweeps each square pixel-by-pixel in raster order, one pixel per `CLOCK_50` cycle. It drives the adapter's `x`/`y`/`colour`/`plot` inputs. The controller's per-pixel XC/YC counters and draw/erase states collapse to one request per body segment, apple, or erase.

---
 rtl/snake_pkg.sv | 25 ++
 rtl/sq_req_fifo.sv | 46 ++++
 rtl/square_plotter.sv | 110 +++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared constants and types for the snake game display path.
package snake_pkg;

   localparam int XSCREEN = 160;
   localparam int YSCREEN = 120;
   localparam int XDIM    = 10;
   localparam int YDIM    = 10;

   localparam logic [2:0] COL_BG    = 3'b000;
   localparam logic [2:0] COL_APPLE = 3'b100;

   typedef enum logic [1:0] {
      SP_IDLE = 2'd0,
      SP_LOAD = 2'd1,
      SP_PLOT = 2'd2
   } sp_state_t;

   // One queued square: top-left corner plus fill colour (18 bits).
   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] colour;
   } sq_req_t;

endpackage

// File: rtl/sq_req_fifo.sv
// Small synchronous FIFO holding pending square requests.
module sq_req_fifo import snake_pkg::*; #(
   parameter  int W     = $bits(sq_req_t),
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          CLOCK_50,
   input  logic          Resetn,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wp, rp;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge CLOCK_50) begin
      if (!Resetn) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (push) begin
            mem[wp] <= wdata;
            wp      <= wp + 1'b1;
         end
         if (pop)
            rp <= rp + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign rdata = mem[rp];
   assign empty = (count == '0);
   assign full  = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/square_plotter.sv
// Queued square rasteriser: sweeps each requested square one pixel per clock
// in raster order and drives the VGA adapter write port.
module square_plotter #(
   parameter int XDIM    = snake_pkg::XDIM,
   parameter int YDIM    = snake_pkg::YDIM,
   parameter int XSCREEN = snake_pkg::XSCREEN,
   parameter int YSCREEN = snake_pkg::YSCREEN,
   parameter int DEPTH   = 4
) (
   input  logic       CLOCK_50,
   input  logic       Resetn,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [7:0] req_x,
   input  logic [6:0] req_y,
   input  logic [2:0] req_colour,
   output logic [7:0] VGA_X,
   output logic [6:0] VGA_Y,
   output logic [2:0] VGA_COLOR,
   output logic       plot,
   output logic       busy,
   output logic       sq_done
);
   import snake_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;

   sp_state_t     state;
   logic [7:0]    base_x, xc;
   logic [6:0]    base_y, yc;
   logic [2:0]    col;
   sq_req_t       wr_req, rd_req;
   logic          push, pop, full, empty;
   logic [CW-1:0] count;
   logic [8:0]    sum_x;
   logic [7:0]    sum_y;
   logic          x_last, y_last;

   assign wr_req    = '{x: req_x, y: req_y, colour: req_colour};
   assign req_ready = !full;
   assign push      = req_valid && req_ready;
   assign pop       = (state == SP_LOAD);

   sq_req_fifo #(.W($bits(sq_req_t)), .DEPTH(DEPTH)) u_fifo (
      .CLOCK_50 (CLOCK_50),
      .Resetn   (Resetn),
      .push     (push),
      .pop      (pop),
      .wdata    (wr_req),
      .rdata    (rd_req),
      .count    (count),
      .full     (full),
      .empty    (empty)
   );

   assign x_last = (xc == 8'(XDIM - 1));
   assign y_last = (yc == 7'(YDIM - 1));

   // Widened sums so off-screen pixels are clipped rather than wrapped.
   assign sum_x = {1'b0, base_x} + {1'b0, xc};
   assign sum_y = {1'b0, base_y} + {1'b0, yc};

   assign VGA_X     = sum_x[7:0];
   assign VGA_Y     = sum_y[6:0];
   assign VGA_COLOR = (state == SP_PLOT) ? col : COL_BG;
   assign plot      = (state == SP_PLOT) && (sum_x < 9'(XSCREEN)) && (sum_y < 8'(YSCREEN));
   assign sq_done   = (state == SP_PLOT) && x_last && y_last;
   assign busy      = (state != SP_IDLE) || (count != '0);

   // Sequencer: pop a request, then walk XC/YC across the square; a push on
   // the last-pixel edge chains straight into the next LOAD.
   always_ff @(posedge CLOCK_50) begin
      if (!Resetn) begin
         state  <= SP_IDLE;
         base_x <= '0;
         base_y <= '0;
         col    <= '0;
         xc     <= '0;
         yc     <= '0;
      end else begin
         case (state)
            SP_IDLE: begin
               if (!empty)
                  state <= SP_LOAD;
            end
            SP_LOAD: begin
               base_x <= rd_req.x;
               base_y <= rd_req.y;
               col    <= rd_req.colour;
               xc     <= '0;
               yc     <= '0;
               state  <= SP_PLOT;
            end
            SP_PLOT: begin
               if (!x_last) begin
                  xc <= xc + 1'b1;
               end else begin
                  xc <= '0;
                  if (!y_last)
                     yc <= yc + 1'b1;
                  else
                     state <= (!empty || push) ? SP_LOAD : SP_IDLE;
               end
            end
            default: state <= SP_IDLE;
         endcase
      end
   end

endmodule
